alien_fire_scheduler: RTL and testbench
=======================================

Name: alien_fire_scheduler

Overview:
- Shares the game's single alien-bomb resource among NUM_ALIENS alien instances.
- Counts frame ticks between shots and round-robin selects the next live alien.
- Latches that alien's position as the bomb launch point, then holds the resource busy until the bomb retires.
- Sits between the alien array (alive flags, flattened positions) and the bomb mover/renderer.

Parameters:
- NUM_ALIENS, 8, number of requesters; power of two, 2..16.
- IDX_W, $clog2(NUM_ALIENS), owner index width.
- FIRE_INTERVAL, 60, frame ticks between a bomb retiring and the next shot; 1..255.
- DROP_OFFSET, 10, pixels added to the alien Y to get the bomb launch Y.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- playing  in  1  game running; low acts as a synchronous clear.
- tick  in  1  one-cycle frame strobe.
- alien_alive  in  NUM_ALIENS  bit i high = alien i alive.
- alien_x_flat  in  10*NUM_ALIENS  alien i X at bits [10i+9:10i].
- alien_y_flat  in  9*NUM_ALIENS  alien i Y at bits [9i+8:9i].
- bomb_done  in  1  pulse from the bomb mover: bomb left the screen or hit the ship.
- bomb_fire  out  1  one-cycle launch pulse.
- bomb_active  out  1  bomb resource is owned.
- bomb_x  out  10  launch X.
- bomb_y  out  9  launch Y.
- bomb_owner  out  IDX_W  index of the firing alien.
- fleet_cleared  out  1  high while playing and alien_alive == 0.

Behaviour:
- Clear condition: reset==0 or playing==0 at a rising edge.
  - state=IDLE, rr_ptr=0, counter=FIRE_INTERVAL.
  - All outputs 0.
  - Clear has priority over everything, including mid-FLIGHT; any in-progress bomb ownership is dropped.
- IDLE: go to WAIT on the next edge once not clearing.
- WAIT:
  - Each tick with counter!=0 decrements counter.
  - When counter==0 and alien_alive!=0, go to SELECT.
  - When counter==0 and no alien is alive, hold WAIT with counter at 0.
- SELECT (exactly 1 cycle):
  - grant = first i with alien_alive[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_ALIENS.
  - Latch bomb_owner=grant and bomb_x=alien X of grant.
  - bomb_y = alien Y + DROP_OFFSET, computed 10-bit and saturated to 479.
  - rr_ptr <= (grant+1) mod NUM_ALIENS, then go to FIRE.
  - alien_alive is sampled only in this cycle. A later death of the owner does not cancel the shot.
- FIRE (1 cycle): bomb_fire=1 and bomb_active=1, then go to FLIGHT.
- FLIGHT:
  - bomb_active stays 1 and bomb_x/y/owner are held.
  - On bomb_done: bomb_active=0 on the next edge, counter=FIRE_INTERVAL, go to WAIT.
- bomb_done outside FLIGHT is ignored. bomb_done in the FIRE cycle is also ignored.
- Latency: from the edge at which counter reaches 0, SELECT is the next cycle and bomb_fire is high the cycle after that (2 cycles).
- A tick in SELECT, FIRE or FLIGHT does not touch counter.
- fleet_cleared is a registered output, updated every cycle from alien_alive, 0 under clear.

Optional Feature:
- Macro: ALIEN_FIRE_JITTER_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on clear) advances every tick.
  - The WAIT reload becomes FIRE_INTERVAL + (lfsr & 8'h1F), giving 0..31 extra ticks.
  - The SELECT search starts at rr_ptr XOR lfsr[IDX_W-1:0] instead of rr_ptr.
- When undefined: fixed interval and pure round-robin exactly as above; no LFSR logic is present.

Decomposition:
- Package alien_pkg:
  - SCREEN_W=640 and SCREEN_H=480 constants.
  - X_W=10 and Y_W=9.
  - State enum fire_state_t {IDLE, WAIT, SELECT, FIRE, FLIGHT}.
- Sub-module rr_pick: combinational priority search over NUM_ALIENS with a start pointer. Returns grant and valid. Kept separate so it can be reused by a later shield or ufo scheduler.

Test Plan (NUM_ALIENS=4, FIRE_INTERVAL=3, DROP_OFFSET=10, macro undefined):
- Release reset, playing=1, alive=4'b1111, alien0 at (100,50), 3 ticks:
  - bomb_fire pulses 2 cycles after the third tick's edge.
  - bomb_x=100, bomb_y=60, owner=0, bomb_active=1.
- Continue with bomb_done pulses after each shot, alive=4'b1011: owner sequence is 1, 3, 0, 1.
- alien2 Y=475, alive=4'b0100: bomb_y=479 (saturated).
- alive drops to 0 during WAIT:
  - fleet_cleared=1 the next cycle.
  - No bomb_fire for 20 ticks.
  - Re-asserting alive=4'b0001 fires owner 0 within 2 cycles.
- Assert reset=0 for 1 cycle during FLIGHT:
  - Next cycle: bomb_active=0, owner=0, rr_ptr=0.
  - After release, the first shot needs 3 fresh ticks.
- bomb_done pulsed during WAIT and in the FIRE cycle: no state change; bomb_active stays 1 through FLIGHT until a later bomb_done.

Source files
------------

// File: rtl/alien_pkg.sv
// alien_pkg: screen geometry, coordinate widths and the fire scheduler state
// encoding shared by the alien fire scheduler and its helpers.
package alien_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SELECT,
        FIRE,
        FLIGHT
    } fire_state_t;

endpackage

// File: rtl/alien_fire_scheduler_if.sv
// alien_fire_scheduler_if: bundles the alien-array inputs and the bomb
// outputs of the fire scheduler. The slave modport is the scheduler's view,
// the master modport is the game side that feeds it and consumes the bomb.
interface alien_fire_scheduler_if
    import alien_pkg::*;
#(
    parameter int NUM_ALIENS = 8,
    parameter int IDX_W      = $clog2(NUM_ALIENS)
);
    logic                      playing;
    logic                      tick;
    logic [NUM_ALIENS-1:0]     alien_alive;
    logic [X_W*NUM_ALIENS-1:0] alien_x_flat;
    logic [Y_W*NUM_ALIENS-1:0] alien_y_flat;
    logic                      bomb_done;
    logic                      bomb_fire;
    logic                      bomb_active;
    logic [X_W-1:0]            bomb_x;
    logic [Y_W-1:0]            bomb_y;
    logic [IDX_W-1:0]          bomb_owner;
    logic                      fleet_cleared;

    modport slave (
        input  playing, tick, alien_alive, alien_x_flat, alien_y_flat, bomb_done,
        output bomb_fire, bomb_active, bomb_x, bomb_y, bomb_owner, fleet_cleared
    );

    modport master (
        output playing, tick, alien_alive, alien_x_flat, alien_y_flat, bomb_done,
        input  bomb_fire, bomb_active, bomb_x, bomb_y, bomb_owner, fleet_cleared
    );

endinterface

// File: rtl/alien_fire_scheduler_rr_pick.sv
// rr_pick: combinational rotating-priority search. Returns the first set
// request at or after 'start', wrapping modulo N (N a power of two).
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] grant,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the closest hit to start wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + IW'(k);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alien_fire_scheduler.sv
// alien_fire_scheduler: shares the single alien bomb among NUM_ALIENS aliens.
// Waits FIRE_INTERVAL frame ticks, picks the next live alien round-robin,
// latches its launch point and holds the bomb until bomb_done.
// Optional macro ALIEN_FIRE_JITTER_EN adds an LFSR that randomises the
// reload interval and the search start point.
module alien_fire_scheduler
    import alien_pkg::*;
#(
    parameter int NUM_ALIENS    = 8,
    parameter int IDX_W         = $clog2(NUM_ALIENS),
    parameter int FIRE_INTERVAL = 60,
    parameter int DROP_OFFSET   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    alien_fire_scheduler_if.slave bus
);

    localparam int CNT_W = 9;

    fire_state_t      state, state_n;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] reload;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] start_ptr;
    logic [IDX_W-1:0] grant;
    logic             grant_vld;
    logic             clear;
    logic             fire_c;
    logic             active_c;
    logic [IDX_W-1:0] owner_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             fleet_q;

    // Launch Y is alien Y plus the drop offset, clamped to the last screen row.
    function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] y);
        logic [X_W-1:0] sum;
        sum = {1'b0, y} + X_W'(DROP_OFFSET);
        if (sum > X_W'(SCREEN_H - 1))
            return Y_W'(SCREEN_H - 1);
        return sum[Y_W-1:0];
    endfunction

    assign clear = ~reset | ~bus.playing;

`ifdef ALIEN_FIRE_JITTER_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR (taps 8,6,5,4) stepped on every frame tick.
    always_ff @(posedge clk) begin
        if (clear)
            lfsr <= 8'hA5;
        else if (bus.tick)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign start_ptr = rr_ptr ^ lfsr[IDX_W-1:0];
    assign reload    = CNT_W'(FIRE_INTERVAL) + CNT_W'(lfsr & 8'h1F);
`else
    assign start_ptr = rr_ptr;
    assign reload    = CNT_W'(FIRE_INTERVAL);
`endif

    rr_pick #(
        .N  (NUM_ALIENS),
        .IW (IDX_W)
    ) u_pick (
        .req   (bus.alien_alive),
        .start (start_ptr),
        .grant (grant),
        .valid (grant_vld)
    );

    // State register; clear drops any bomb ownership immediately.
    always_ff @(posedge clk) begin
        if (clear)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and bomb strobe decode.
    always_comb begin
        state_n  = state;
        fire_c   = 1'b0;
        active_c = 1'b0;
        case (state)
            IDLE:   state_n = WAIT;
            WAIT:   if (counter == '0 && |bus.alien_alive) state_n = SELECT;
            // Owner may have died since WAIT; fall back and retry then.
            SELECT: state_n = grant_vld ? FIRE : WAIT;
            FIRE: begin
                fire_c   = 1'b1;
                active_c = 1'b1;
                state_n  = FLIGHT;
            end
            FLIGHT: begin
                active_c = 1'b1;
                if (bus.bomb_done) state_n = WAIT;
            end
            default: state_n = IDLE;
        endcase
    end

    // Interval counter, round-robin pointer, launch point and fleet status.
    always_ff @(posedge clk) begin
        if (clear) begin
            counter <= CNT_W'(FIRE_INTERVAL);
            rr_ptr  <= '0;
            owner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fleet_q <= 1'b0;
        end else begin
            fleet_q <= ~|bus.alien_alive;
            case (state)
                WAIT: begin
                    if (bus.tick && counter != '0)
                        counter <= counter - 1'b1;
                end
                SELECT: begin
                    if (grant_vld) begin
                        owner_q <= grant;
                        x_q     <= bus.alien_x_flat[X_W*int'(grant) +: X_W];
                        y_q     <= sat_y(bus.alien_y_flat[Y_W*int'(grant) +: Y_W]);
                        rr_ptr  <= grant + IDX_W'(1);
                    end
                end
                FLIGHT: begin
                    if (bus.bomb_done)
                        counter <= reload;
                end
                default: ;
            endcase
        end
    end

    assign bus.bomb_fire     = fire_c;
    assign bus.bomb_active   = active_c;
    assign bus.bomb_x        = x_q;
    assign bus.bomb_y        = y_q;
    assign bus.bomb_owner    = owner_q;
    assign bus.fleet_cleared = fleet_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb_alien_fire_scheduler: directed bench for alien_fire_scheduler with
// NUM_ALIENS=4, FIRE_INTERVAL=3, DROP_OFFSET=10. Expected shots are queued
// by the stimulus and checked by a monitor whenever bomb_fire is seen.
module tb_alien_fire_scheduler;
    import alien_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alien_fire_scheduler_if #(.NUM_ALIENS(4)) bus ();

    alien_fire_scheduler #(
        .NUM_ALIENS    (4),
        .IDX_W         (2),
        .FIRE_INTERVAL (3),
        .DROP_OFFSET   (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int owner;
        int x;
        int y;
    } shot_t;

    shot_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            step(1);
            bus.tick = 1'b0;
        end
    endtask

    task automatic done_pulse();
        bus.bomb_done = 1'b1;
        step(1);
        bus.bomb_done = 1'b0;
    endtask

    // Queue the expected shot, then wait (bounded) for the launch strobe.
    task automatic expect_shot(input string name, input int owner, input int x, input int y);
        int n;
        shot_t s;
        s.owner = owner;
        s.x     = x;
        s.y     = y;
        exp_q.push_back(s);
        n = 0;
        while (bus.bomb_fire !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        chk({name, "_latency"}, n, 2);
    endtask

    // Monitor: every launch must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.bomb_fire === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", int'(bus.bomb_fire), 0);
            end else begin
                shot_t e;
                e = exp_q.pop_front();
                chk("owner", int'(bus.bomb_owner), e.owner);
                chk("bomb_x", int'(bus.bomb_x), e.x);
                chk("bomb_y", int'(bus.bomb_y), e.y);
                chk("active_at_fire", int'(bus.bomb_active), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int seq_owner[4] = '{1, 3, 0, 1};
    int seq_y[4]     = '{70, 110, 60, 70};

    initial begin
        reset            = 1'b0;
        bus.playing      = 1'b1;
        bus.tick         = 1'b0;
        bus.bomb_done    = 1'b0;
        bus.alien_alive  = 4'b1111;
        bus.alien_x_flat = {10'd400, 10'd300, 10'd200, 10'd100};
        bus.alien_y_flat = {9'd100, 9'd475, 9'd60, 9'd50};
        step(3);
        chk("rst_active", int'(bus.bomb_active), 0);
        chk("rst_fire", int'(bus.bomb_fire), 0);
        chk("rst_owner", int'(bus.bomb_owner), 0);
        chk("rst_x", int'(bus.bomb_x), 0);
        chk("rst_y", int'(bus.bomb_y), 0);
        chk("rst_fleet", int'(bus.fleet_cleared), 0);

        // First shot: alien 0 after three ticks.
        reset = 1'b1;
        step(1);
        tick_pulse(3);
        expect_shot("s0", 0, 100, 60);
        step(1);
        chk("flight_active", int'(bus.bomb_active), 1);
        chk("flight_fire", int'(bus.bomb_fire), 0);

        // Round-robin over aliens 0,1,3.
        bus.alien_alive = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            chk("retired_active", int'(bus.bomb_active), 0);
            tick_pulse(3);
            expect_shot("rr", seq_owner[i], 100 + 100 * seq_owner[i], seq_y[i]);
            step(1);
        end

        // Saturated launch Y.
        bus.alien_alive = 4'b0100;
        done_pulse();
        tick_pulse(3);
        expect_shot("sat", 2, 300, 479);
        step(1);

        // Fleet empties during WAIT: no shots.
        done_pulse();
        bus.alien_alive = 4'b0000;
        step(1);
        chk("fleet_cleared", int'(bus.fleet_cleared), 1);
        tick_pulse(20);
        chk("empty_active", int'(bus.bomb_active), 0);
        bus.alien_alive = 4'b0001;
        expect_shot("revive", 0, 100, 60);
        chk("fleet_back", int'(bus.fleet_cleared), 0);
        step(1);

        // Reset mid-flight drops ownership and the pointer.
        reset = 1'b0;
        step(1);
        chk("midrst_active", int'(bus.bomb_active), 0);
        chk("midrst_owner", int'(bus.bomb_owner), 0);
        chk("midrst_fire", int'(bus.bomb_fire), 0);
        reset = 1'b1;
        bus.alien_alive = 4'b1111;
        step(1);
        tick_pulse(2);
        step(5);
        chk("fresh_ticks_nofire", int'(bus.bomb_fire), 0);
        tick_pulse(1);
        expect_shot("post_rst", 0, 100, 60);

        // bomb_done in the FIRE cycle is ignored.
        bus.bomb_done = 1'b1;
        step(1);
        bus.bomb_done = 1'b0;
        chk("done_in_fire", int'(bus.bomb_active), 1);
        step(3);
        chk("hold_flight", int'(bus.bomb_active), 1);
        done_pulse();
        chk("done_flight", int'(bus.bomb_active), 0);

        // bomb_done in WAIT leaves the interval untouched.
        done_pulse();
        chk("done_in_wait", int'(bus.bomb_active), 0);
        tick_pulse(2);
        step(4);
        chk("wait_nofire", int'(bus.bomb_fire), 0);
        tick_pulse(1);
        expect_shot("after_wait_done", 1, 200, 70);
        step(1);

        // playing low clears like reset.
        bus.playing = 1'b0;
        step(1);
        chk("play_clear_active", int'(bus.bomb_active), 0);
        chk("play_clear_owner", int'(bus.bomb_owner), 0);
        bus.playing = 1'b1;
        step(2);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
